wbi_slave_node: RTL and testbench

- Target-side counterpart of the interconnect master node. Accepts command-channel entries (valid/ready, one entry per write beat, one entry per read burst) and replays them as a burst Wishbone cycle on a slave port.
- Read beats are returned on the response channel, with last-ack and error flags.
- Sits between the interconnect crossbar/arbiter output and a slave peripheral such as SRAM, QSPI or registers.

---
 rtl/wbi_slave_node.sv | 205 ++++++++++++++++++++
 tb/tb_wbi_slave_node.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wbi_slave_node.sv
// Interconnect slave node: queues command entries and replays them as burst
// Wishbone cycles on the slave port, returning read beats through a response FIFO.
module wbi_slave_node #(
  parameter int unsigned AW  = 32,
  parameter int unsigned BW  = 4,
  parameter int unsigned BL  = 10,
  parameter int unsigned DW  = 32,
  parameter int unsigned CDP = 4,
  parameter int unsigned RDP = 4
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          cmd_wval_i,
  output logic          cmd_wrdy_o,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic          cmd_we_i,
  input  logic [DW-1:0] cmd_dat_i,
  input  logic [BW-1:0] cmd_sel_i,
  input  logic [3:0]    cmd_tid_i,
  input  logic [BL-1:0] cmd_bl_i,
  output logic          res_rval_o,
  input  logic          res_rrdy_i,
  output logic [DW-1:0] res_dat_o,
  output logic          res_ack_o,
  output logic          res_lack_o,
  output logic          res_err_o,
  output logic [3:0]    res_tid_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic [AW-1:0] wbs_adr_o,
  output logic          wbs_we_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic [BW-1:0] wbs_sel_o,
  output logic [BL-1:0] wbs_bl_o,
  output logic          wbs_bry_o,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_lack_i,
  input  logic          wbs_err_i
);
  localparam int unsigned CPW = $clog2(CDP);
  localparam int unsigned RPW = $clog2(RDP);
  localparam logic [CPW:0] CDP_N = (CPW+1)'(CDP);
  localparam logic [RPW:0] RDP_N = (RPW+1)'(RDP);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state_q, state_d;

  logic [AW-1:0]  cf_adr [CDP];
  logic           cf_we  [CDP];
  logic [DW-1:0]  cf_dat [CDP];
  logic [BW-1:0]  cf_sel [CDP];
  logic [3:0]     cf_tid [CDP];
  logic [BL-1:0]  cf_bl  [CDP];
  logic [CPW-1:0] cf_wp, cf_rp;
  logic [CPW:0]   cf_cnt;
  logic           cf_empty, cmd_push, cmd_pop;

  logic [DW-1:0]  rf_dat  [RDP];
  logic           rf_err  [RDP];
  logic           rf_lack [RDP];
  logic [RPW-1:0] rf_wp, rf_rp;
  logic [RPW:0]   rf_cnt;
  logic           rf_empty, rf_push, rf_pop, rf_last;

  logic [BL-1:0]  cnt_q, cnt_d, bl_q, bl_d, head_bl;
  logic [3:0]     tid_q, tid_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [BW-1:0]  sel_q, sel_d;
  logic           bry_c, beat_done;

  assign cf_empty   = (cf_cnt == '0);
  assign cmd_wrdy_o = (cf_cnt != CDP_N);
  assign cmd_push   = cmd_wval_i && cmd_wrdy_o;
  assign rf_empty   = (rf_cnt == '0);
  assign rf_pop     = res_rval_o && res_rrdy_i;
  assign head_bl    = (cf_bl[cf_rp] == '0) ? BL'(1) : cf_bl[cf_rp];

  // FIFO payload storage; pointers alone define validity so no reset is needed
  always_ff @(posedge mclk) begin
    if (cmd_push) begin
      cf_adr[cf_wp] <= cmd_adr_i;
      cf_we[cf_wp]  <= cmd_we_i;
      cf_dat[cf_wp] <= cmd_dat_i;
      cf_sel[cf_wp] <= cmd_sel_i;
      cf_tid[cf_wp] <= cmd_tid_i;
      cf_bl[cf_wp]  <= cmd_bl_i;
    end
    if (rf_push) begin
      rf_dat[rf_wp]  <= wbs_dat_i;
      rf_err[rf_wp]  <= wbs_err_i;
      rf_lack[rf_wp] <= rf_last;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bl_q    <= '0;
      tid_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      cf_wp   <= '0;
      cf_rp   <= '0;
      cf_cnt  <= '0;
      rf_wp   <= '0;
      rf_rp   <= '0;
      rf_cnt  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bl_q    <= bl_d;
      tid_q   <= tid_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      if (cmd_push) cf_wp <= cf_wp + CPW'(1);
      if (cmd_pop)  cf_rp <= cf_rp + CPW'(1);
      cf_cnt <= cf_cnt + (CPW+1)'(cmd_push) - (CPW+1)'(cmd_pop);
      if (rf_push) rf_wp <= rf_wp + RPW'(1);
      if (rf_pop)  rf_rp <= rf_rp + RPW'(1);
      rf_cnt <= rf_cnt + (RPW+1)'(rf_push) - (RPW+1)'(rf_pop);
    end
  end

  // Burst sequencer; a non-zero count in IDLE means leftover write beats to discard
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bl_d      = bl_q;
    tid_d     = tid_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    cmd_pop   = 1'b0;
    rf_push   = 1'b0;
    rf_last   = 1'b0;
    bry_c     = 1'b0;
    beat_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          if (!cf_empty) begin
            cmd_pop = 1'b1;
            cnt_d   = cnt_q - BL'(1);
          end
        end else if (!cf_empty) begin
          if (cf_we[cf_rp]) begin
            cnt_d   = head_bl;
            bl_d    = cf_bl[cf_rp];
            state_d = WRITE;
          end else if (rf_empty) begin
            cmd_pop = 1'b1;
            cnt_d   = head_bl;
            bl_d    = cf_bl[cf_rp];
            tid_d   = cf_tid[cf_rp];
            adr_d   = cf_adr[cf_rp];
            sel_d   = cf_sel[cf_rp];
            state_d = READ;
          end
        end
      end
      WRITE: begin
        bry_c     = !cf_empty;
        beat_done = wbs_ack_i && bry_c;
        if (beat_done) begin
          cmd_pop = 1'b1;
          cnt_d   = cnt_q - BL'(1);
          if ((cnt_q == BL'(1)) || wbs_lack_i) state_d = IDLE;
        end
      end
      READ: begin
        bry_c     = (rf_cnt != RDP_N);
        beat_done = wbs_ack_i && bry_c;
        if (beat_done) begin
          rf_push = 1'b1;
          rf_last = (cnt_q == BL'(1)) || wbs_lack_i;
          if (rf_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - BL'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wbs_cyc_o  = (state_q != IDLE);
  assign wbs_stb_o  = (state_q != IDLE);
  assign wbs_we_o   = (state_q == WRITE);
  assign wbs_adr_o  = (state_q == WRITE) ? cf_adr[cf_rp] : adr_q;
  assign wbs_dat_o  = (state_q == WRITE) ? cf_dat[cf_rp] : '0;
  assign wbs_sel_o  = (state_q == WRITE) ? cf_sel[cf_rp] : sel_q;
  assign wbs_bl_o   = bl_q;
  assign wbs_bry_o  = bry_c;

  assign res_rval_o = !rf_empty;
  assign res_ack_o  = !rf_empty;
  assign res_dat_o  = rf_dat[rf_rp];
  assign res_err_o  = rf_err[rf_rp];
  assign res_lack_o = rf_lack[rf_rp];
  assign res_tid_o  = tid_q;

endmodule

// File: tb/tb_wbi_slave_node.sv
// Randomized bench for wbi_slave_node: a burst-level scoreboard predicts slave
// beats and read responses from the queued commands.
module tb_wbi_slave_node;
  localparam int unsigned AW = 32, BW = 4, BL = 10, DW = 32, CDP = 4, RDP = 4;

  logic          mclk = 1'b0;
  logic          reset;
  logic          cmd_wval_i, cmd_wrdy_o, cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [BW-1:0] cmd_sel_i;
  logic [3:0]    cmd_tid_i;
  logic [BL-1:0] cmd_bl_i;
  logic          res_rval_o, res_rrdy_i, res_ack_o, res_lack_o, res_err_o;
  logic [DW-1:0] res_dat_o;
  logic [3:0]    res_tid_o;
  logic          wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_bry_o;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o, wbs_dat_i;
  logic [BW-1:0] wbs_sel_o;
  logic [BL-1:0] wbs_bl_o;
  logic          wbs_ack_i, wbs_lack_i, wbs_err_i;

  wbi_slave_node #(.AW(AW), .BW(BW), .BL(BL), .DW(DW), .CDP(CDP), .RDP(RDP)) dut (
    .mclk(mclk), .reset(reset),
    .cmd_wval_i(cmd_wval_i), .cmd_wrdy_o(cmd_wrdy_o), .cmd_adr_i(cmd_adr_i),
    .cmd_we_i(cmd_we_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .cmd_tid_i(cmd_tid_i), .cmd_bl_i(cmd_bl_i),
    .res_rval_o(res_rval_o), .res_rrdy_i(res_rrdy_i), .res_dat_o(res_dat_o),
    .res_ack_o(res_ack_o), .res_lack_o(res_lack_o), .res_err_o(res_err_o),
    .res_tid_o(res_tid_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_adr_o(wbs_adr_o),
    .wbs_we_o(wbs_we_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_bl_o(wbs_bl_o), .wbs_bry_o(wbs_bry_o), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i), .wbs_lack_i(wbs_lack_i), .wbs_err_i(wbs_err_i)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [BW-1:0] sel;
    logic [3:0]    tid;
    logic [BL-1:0] bl;
  } cmd_t;
  typedef struct packed {
    logic          we;
    logic [BL-1:0] bl;
    logic [31:0]   beats;
    logic [3:0]    tid;
    logic [AW-1:0] adr;
    logic [BW-1:0] sel;
  } burst_t;
  typedef struct packed {
    logic [DW-1:0] dat;
    logic          err;
    logic          lack;
    logic [3:0]    tid;
  } rsp_t;

  cmd_t   cmd_q[$];
  cmd_t   wbeat_q[$];
  burst_t burst_q[$];
  rsp_t   rsp_q[$];

  int unsigned n_pass = 0, n_total = 0;
  int unsigned beats_acc = 0, rsp_seen = 0;
  int unsigned rrdy_thr = 8;
  bit          lack_en = 1'b1;
  bit          expect_idle = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One burst = bl write entries or a single read entry; bl of 0 means one beat
  task automatic add_burst(input logic we, input logic [BL-1:0] bl, input logic [3:0] tid,
                           input logic [AW-1:0] adr);
    cmd_t c;
    burst_t b;
    int unsigned n;
    n = (bl == '0) ? 1 : int'(bl);
    b.we = we; b.bl = bl; b.beats = 32'(n); b.tid = tid; b.adr = adr; b.sel = BW'($urandom);
    if (we) begin
      for (int i = 0; i < n; i++) begin
        c.we = 1'b1; c.adr = adr + AW'(4 * i); c.dat = DW'($urandom);
        c.sel = BW'($urandom); c.tid = tid; c.bl = bl;
        cmd_q.push_back(c);
        wbeat_q.push_back(c);
      end
    end else begin
      c.we = 1'b0; c.adr = adr; c.dat = DW'($urandom); c.sel = b.sel; c.tid = tid; c.bl = bl;
      cmd_q.push_back(c);
    end
    burst_q.push_back(b);
  endtask

  task automatic accept_beat();
    burst_t b;
    cmd_t w;
    rsp_t e;
    logic last;
    beats_acc++;
    if (burst_q.size() == 0) begin
      check("beat_without_burst", 64'(1), 64'(0));
      return;
    end
    b = burst_q[0];
    check("beat_we", 64'(wbs_we_o), 64'(b.we));
    check("beat_bl", 64'(wbs_bl_o), 64'(b.bl));
    last = (b.beats == 32'd1) || wbs_lack_i;
    if (b.we) begin
      w = wbeat_q.pop_front();
      check("wr_adr", 64'(wbs_adr_o), 64'(w.adr));
      check("wr_dat", 64'(wbs_dat_o), 64'(w.dat));
      check("wr_sel", 64'(wbs_sel_o), 64'(w.sel));
    end else begin
      check("rd_adr", 64'(wbs_adr_o), 64'(b.adr));
      check("rd_sel", 64'(wbs_sel_o), 64'(b.sel));
      e.dat = wbs_dat_i; e.err = wbs_err_i; e.lack = last; e.tid = b.tid;
      rsp_q.push_back(e);
    end
    b.beats = b.beats - 32'd1;
    if (last) begin
      if (b.we) repeat (b.beats) void'(wbeat_q.pop_front());
      void'(burst_q.pop_front());
      expect_idle = 1'b1;
    end else begin
      burst_q[0] = b;
    end
  endtask

  // One clock of traffic: outputs are stable at negedge, inputs set for the next edge
  task automatic step();
    cmd_t c;
    rsp_t e;
    logic push;
    @(negedge mclk);
    if (expect_idle) check("cyc_drop_after_last", 64'(wbs_cyc_o), 64'(0));
    expect_idle = 1'b0;
    if (wbs_stb_o) check("stb_with_burst", 64'(burst_q.size() != 0), 64'(1));

    if (cmd_q.size() != 0 && $urandom_range(3) != 0) begin
      c = cmd_q[0];
      cmd_wval_i = 1'b1; cmd_we_i = c.we; cmd_adr_i = c.adr; cmd_dat_i = c.dat;
      cmd_sel_i = c.sel; cmd_tid_i = c.tid; cmd_bl_i = c.bl;
    end else begin
      cmd_wval_i = 1'b0;
    end
    push = cmd_wval_i && cmd_wrdy_o;

    res_rrdy_i = ($urandom_range(7) < rrdy_thr);
    if (res_rval_o && res_rrdy_i) begin
      rsp_seen++;
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        e = rsp_q.pop_front();
        check("rsp_dat", 64'(res_dat_o), 64'(e.dat));
        check("rsp_err", 64'(res_err_o), 64'(e.err));
        check("rsp_lack", 64'(res_lack_o), 64'(e.lack));
        check("rsp_tid", 64'(res_tid_o), 64'(e.tid));
        check("rsp_ack", 64'(res_ack_o), 64'(1));
      end
    end

    wbs_ack_i  = wbs_stb_o && ($urandom_range(3) != 0);
    wbs_lack_i = lack_en && wbs_ack_i && ($urandom_range(9) == 0);
    wbs_err_i  = ($urandom_range(5) == 0);
    wbs_dat_i  = DW'($urandom);
    if (wbs_stb_o && wbs_ack_i && wbs_bry_o) accept_beat();
    if (push) void'(cmd_q.pop_front());
  endtask

  task automatic drain(input string tag);
    int unsigned guard;
    guard = 0;
    while ((cmd_q.size() + burst_q.size() + rsp_q.size()) != 0 && guard < 30000) begin
      if (guard % 64 == 0) rrdy_thr = $urandom_range(8);
      step();
      guard++;
    end
    check(tag, 64'(guard < 30000), 64'(1));
    rrdy_thr = 8;
    repeat (6) step();
    check("idle_cyc", 64'(wbs_cyc_o), 64'(0));
    check("idle_rval", 64'(res_rval_o), 64'(0));
    check("idle_wrdy", 64'(cmd_wrdy_o), 64'(1));
  endtask

  initial begin
    int unsigned guard;
    int unsigned rsp0;
    reset = 1'b1;
    cmd_wval_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0;
    cmd_sel_i = '0; cmd_tid_i = '0; cmd_bl_i = '0; res_rrdy_i = 1'b0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_lack_i = 1'b0; wbs_err_i = 1'b0;
    repeat (3) @(negedge mclk);
    reset = 1'b0;
    check("rst_cyc", 64'(wbs_cyc_o), 64'(0));
    check("rst_stb", 64'(wbs_stb_o), 64'(0));
    check("rst_we", 64'(wbs_we_o), 64'(0));
    check("rst_bry", 64'(wbs_bry_o), 64'(0));
    check("rst_rval", 64'(res_rval_o), 64'(0));
    check("rst_wrdy", 64'(cmd_wrdy_o), 64'(1));

    add_burst(1'b1, BL'(1), 4'h1, AW'(32'h100));
    add_burst(1'b1, BL'(4), 4'h2, AW'(32'h200));
    add_burst(1'b0, BL'(4), 4'h5, AW'(32'h300));
    add_burst(1'b0, BL'(3), 4'h6, AW'(32'h400));
    add_burst(1'b0, BL'(2), 4'h7, AW'(32'h500));
    add_burst(1'b0, BL'(0), 4'h8, AW'(32'h600));
    add_burst(1'b1, BL'(0), 4'h9, AW'(32'h700));
    for (int i = 0; i < 60; i++)
      add_burst(1'($urandom_range(1)), BL'($urandom_range(6)), 4'($urandom),
                AW'($urandom) & ~AW'(3));
    drain("random_drain_timeout");

    // Abandon a write burst mid-flight with reset
    lack_en = 1'b0;
    add_burst(1'b1, BL'(4), 4'h3, AW'(32'h800));
    beats_acc = 0;
    guard = 0;
    while (beats_acc < 2 && guard < 500) begin
      step();
      guard++;
    end
    check("mid_burst_beats", 64'(beats_acc), 64'(2));
    @(negedge mclk);
    check("mid_burst_cyc", 64'(wbs_cyc_o), 64'(1));
    reset = 1'b1; cmd_wval_i = 1'b0; wbs_ack_i = 1'b0; res_rrdy_i = 1'b0;
    @(negedge mclk);
    reset = 1'b0;
    cmd_q.delete(); wbeat_q.delete(); burst_q.delete(); rsp_q.delete();
    expect_idle = 1'b0;
    check("post_rst_cyc", 64'(wbs_cyc_o), 64'(0));
    check("post_rst_wrdy", 64'(cmd_wrdy_o), 64'(1));
    check("post_rst_rval", 64'(res_rval_o), 64'(0));
    rsp0 = rsp_seen;
    add_burst(1'b0, BL'(1), 4'hA, AW'(32'h900));
    drain("post_rst_drain_timeout");
    check("post_rst_read_rsp", 64'(rsp_seen - rsp0), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
